// File: rtl/fifo_bram_port_ctrl.sv
// Two-producer / one-consumer front end for an external BRAM FIFO: round-robin
// write arbitration plus a credit-based read sequencer that hides BRAM read latency.
module fifo_bram_port_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  A_Req,
  input  logic [DATA_WIDTH-1:0] A_Data,
  output logic                  A_Grant,
  input  logic                  B_Req,
  input  logic [DATA_WIDTH-1:0] B_Data,
  output logic                  B_Grant,
  output logic                  Out_Valid,
  output logic [DATA_WIDTH-1:0] Out_Data,
  input  logic                  Out_Ready,
  output logic                  FIFO_Write,
  output logic [DATA_WIDTH-1:0] FIFO_Write_data,
  output logic                  FIFO_Read,
  input  logic [DATA_WIDTH-1:0] FIFO_Read_data,
  input  logic                  FIFO_Empty,
  input  logic                  FIFO_Full
);
  localparam int BUF_DEPTH = READ_LATENCY + 1;
  localparam int PW        = (BUF_DEPTH > 2) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW        = $clog2(2 * BUF_DEPTH + 1);

  typedef enum logic {LAST_A = 1'b0, LAST_B = 1'b1} last_t;

  // ---------------- write arbiter ----------------
  last_t r_last;
  logic  w_a_win, w_b_win;

  assign w_a_win = A_Req & (~B_Req | (r_last == LAST_B));
  assign w_b_win = B_Req & (~A_Req | (r_last == LAST_A));

  // Grants are gated by reset so the FIFO never sees a write while held in reset.
  assign A_Grant         = Reset & ~FIFO_Full & w_a_win;
  assign B_Grant         = Reset & ~FIFO_Full & w_b_win;
  assign FIFO_Write      = A_Grant | B_Grant;
  assign FIFO_Write_data = B_Grant ? B_Data : A_Data;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)       r_last <= LAST_B;
    else if (A_Grant) r_last <= LAST_A;
    else if (B_Grant) r_last <= LAST_B;
  end

  // ---------------- read sequencer ----------------
  logic [DATA_WIDTH-1:0] r_buf [BUF_DEPTH];
  logic [PW-1:0]         r_wptr, r_rptr;
  logic [CW-1:0]         r_cnt;
  logic [READ_LATENCY:1] r_vld_pipe;
  logic [CW-1:0]         w_infl, w_used;
  logic                  w_pop, w_cap;

  function automatic logic [PW-1:0] f_nxt(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_pop = Out_Valid & Out_Ready;
  assign w_cap = r_vld_pipe[READ_LATENCY];

  always_comb begin
    w_infl = '0;
    for (int i = 1; i <= READ_LATENCY; i++) w_infl = w_infl + CW'(r_vld_pipe[i]);
  end

  // A slot freed by this cycle's pop can be re-credited immediately, which is
  // what sustains one word per cycle with only READ_LATENCY+1 buffer entries.
  assign w_used    = r_cnt - CW'(w_pop) + w_infl;
  assign FIFO_Read = Reset & ~FIFO_Empty & (w_used < CW'(BUF_DEPTH));

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_vld_pipe <= '0;
    end else begin
      r_vld_pipe[1] <= FIFO_Read;
      for (int i = 2; i <= READ_LATENCY; i++) r_vld_pipe[i] <= r_vld_pipe[i-1];
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < BUF_DEPTH; i++) r_buf[i] <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_cap) begin
        r_buf[r_wptr] <= FIFO_Read_data;
        r_wptr        <= f_nxt(r_wptr);
      end
      if (w_pop) r_rptr <= f_nxt(r_rptr);
      r_cnt <= r_cnt + CW'(w_cap) - CW'(w_pop);
    end
  end

  // EMPTY: r_cnt==0 and no reads in flight; FILLING: reads in flight; STREAMING: r_cnt>0.
  assign Out_Valid = (r_cnt != '0);
  assign Out_Data  = r_buf[r_rptr];

endmodule

// File: tb/tb_fifo_bram_port_ctrl.sv
// Scoreboard bench: directed stimulus pushes expected FIFO writes and consumer
// words into queues; a negedge monitor pops and compares them as the DUT emits them.
module tb_fifo_bram_port_ctrl;
  logic       Clk = 0;
  logic       Reset;
  logic       A_Req, B_Req, A_Grant, B_Grant;
  logic [7:0] A_Data, B_Data;
  logic       Out_Valid, Out_Ready;
  logic [7:0] Out_Data;
  logic       FIFO_Write, FIFO_Read, FIFO_Empty, FIFO_Full;
  logic [7:0] FIFO_Write_data, FIFO_Read_data;
  logic       force_full;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [7:0] wq[$];
  logic [7:0] oq[$];
  int pop_cyc[$];

  fifo_bram_port_ctrl #(.DATA_WIDTH(8), .READ_LATENCY(1)) dut (
    .Clk(Clk), .Reset(Reset),
    .A_Req(A_Req), .A_Data(A_Data), .A_Grant(A_Grant),
    .B_Req(B_Req), .B_Data(B_Data), .B_Grant(B_Grant),
    .Out_Valid(Out_Valid), .Out_Data(Out_Data), .Out_Ready(Out_Ready),
    .FIFO_Write(FIFO_Write), .FIFO_Write_data(FIFO_Write_data),
    .FIFO_Read(FIFO_Read), .FIFO_Read_data(FIFO_Read_data),
    .FIFO_Empty(FIFO_Empty), .FIFO_Full(FIFO_Full)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // Behavioural FIFO_BRAM: registered Empty/Full, one-cycle read data.
  logic [7:0] m_mem [16];
  logic [4:0] m_cnt, m_nxt;
  logic [3:0] m_wp, m_rp;
  logic       m_empty, m_full, m_wr, m_rdv;
  logic [7:0] m_rd;
  assign m_wr  = FIFO_Write && !FIFO_Full;
  assign m_rdv = FIFO_Read && !m_empty;
  assign m_nxt = m_cnt + 5'(m_wr) - 5'(m_rdv);
  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      m_cnt <= 0; m_wp <= 0; m_rp <= 0; m_empty <= 1; m_full <= 0; m_rd <= 0;
    end else begin
      if (m_wr)  begin m_mem[m_wp] <= FIFO_Write_data; m_wp <= m_wp + 4'd1; end
      if (m_rdv) begin m_rd <= m_mem[m_rp]; m_rp <= m_rp + 4'd1; end
      m_cnt   <= m_nxt;
      m_empty <= (m_nxt == 0);
      m_full  <= (m_nxt == 16);
    end
  end
  assign FIFO_Empty     = m_empty;
  assign FIFO_Full      = m_full | force_full;
  assign FIFO_Read_data = m_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge Clk) begin
    if (Reset) begin
      if (A_Grant && B_Grant) begin
        n_checks++; n_errors++;
        $display("FAIL dual_grant: got both grants, required at most one");
      end
      if (FIFO_Write) begin
        n_checks++;
        if (wq.size() == 0) begin
          n_errors++;
          $display("FAIL wr_unexpected: got write %0h, required none", FIFO_Write_data);
        end else begin
          logic [7:0] e;
          e = wq.pop_front();
          if (FIFO_Write_data !== e) begin
            n_errors++;
            $display("FAIL wr_data: got %0h, required %0h", FIFO_Write_data, e);
          end
        end
      end
      if (Out_Valid && Out_Ready) begin
        n_checks++;
        pop_cyc.push_back(cyc);
        if (oq.size() == 0) begin
          n_errors++;
          $display("FAIL out_unexpected: got word %0h, required none", Out_Data);
        end else begin
          logic [7:0] e;
          e = oq.pop_front();
          if (Out_Data !== e) begin
            n_errors++;
            $display("FAIL out_data: got %0h, required %0h", Out_Data, e);
          end
        end
      end
    end
  end

  task automatic wait_drain(input string name);
    int k = 0;
    while ((oq.size() != 0 || wq.size() != 0) && k < 40) begin
      @(posedge Clk); k++;
    end
    #1;
    chk(name, oq.size() + wq.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int rd_cnt, v_cnt, rd_cyc, v_cyc;
    Reset = 0; A_Req = 0; B_Req = 0; A_Data = 0; B_Data = 0;
    Out_Ready = 0; force_full = 0;

    // Reset values while inputs toggle
    for (int i = 0; i < 4; i++) begin
      @(posedge Clk); #1;
      A_Req = (i % 2 == 0); B_Req = 1'b1; Out_Ready = (i % 2 == 1);
      A_Data = 8'(i * 17); B_Data = 8'(i * 3 + 1);
      @(negedge Clk);
      chk("rst_outs", {A_Grant, B_Grant, FIFO_Write, FIFO_Read, Out_Valid}, 0);
      chk("rst_data", Out_Data, 0);
    end

    // Release: A wins first tie, then strict alternation at full rate
    A_Req = 1; B_Req = 1; A_Data = 8'h0A; B_Data = 8'h0B; Out_Ready = 1;
    for (int i = 0; i < 6; i++) begin
      wq.push_back((i % 2 == 0) ? 8'h0A : 8'h0B);
      oq.push_back((i % 2 == 0) ? 8'h0A : 8'h0B);
    end
    pop_cyc.delete();
    @(posedge Clk); #1; Reset = 1;
    @(negedge Clk);
    chk("first_grant", {A_Grant, B_Grant}, 2'b10);
    repeat (6) @(posedge Clk);
    #1; A_Req = 0; B_Req = 0;
    wait_drain("rr_drain");
    chk("rr_pops", pop_cyc.size(), 6);
    if (pop_cyc.size() == 6) chk("rr_throughput", pop_cyc[5] - pop_cyc[0], 5);

    // Full blocking; B was served last so A wins after release
    force_full = 1; A_Req = 1; B_Req = 1; A_Data = 8'h11; B_Data = 8'h22;
    repeat (3) begin
      @(negedge Clk);
      chk("full_block", {A_Grant, B_Grant, FIFO_Write}, 3'b000);
      @(posedge Clk); #1;
    end
    force_full = 0;
    wq.push_back(8'h11); wq.push_back(8'h22);
    oq.push_back(8'h11); oq.push_back(8'h22);
    @(negedge Clk);
    chk("after_full_A", {A_Grant, B_Grant}, 2'b10);
    @(posedge Clk); #1;
    @(negedge Clk);
    chk("after_full_B", {A_Grant, B_Grant}, 2'b01);
    @(posedge Clk); #1; A_Req = 0; B_Req = 0;
    wait_drain("full_drain");

    // Back-pressure: only BUF_DEPTH reads with Out_Ready low
    Out_Ready = 0; rd_cnt = 0;
    for (int i = 1; i <= 5; i++) begin
      A_Req = 1; A_Data = 8'(i);
      wq.push_back(8'(i)); oq.push_back(8'(i));
      @(negedge Clk); if (FIFO_Read) rd_cnt++;
      @(posedge Clk); #1;
    end
    A_Req = 0;
    repeat (10) begin
      @(negedge Clk); if (FIFO_Read) rd_cnt++;
      @(posedge Clk); #1;
    end
    chk("bp_reads", rd_cnt, 2);
    chk("bp_valid", Out_Valid, 1);
    chk("bp_head", Out_Data, 8'h01);
    Out_Ready = 1; v_cnt = 0;
    repeat (5) begin
      @(negedge Clk); if (Out_Valid) v_cnt++;
      @(posedge Clk); #1;
    end
    chk("bp_nogap", v_cnt, 5);
    wait_drain("bp_drain");

    // Single word: one read, one valid cycle, READ_LATENCY+1 read-to-valid
    A_Req = 1; A_Data = 8'h7E; wq.push_back(8'h7E); oq.push_back(8'h7E);
    @(posedge Clk); #1; A_Req = 0;
    rd_cnt = 0; v_cnt = 0; rd_cyc = 0; v_cyc = 0;
    repeat (12) begin
      @(negedge Clk);
      if (FIFO_Read) begin rd_cnt++; rd_cyc = cyc; end
      if (Out_Valid) begin v_cnt++; v_cyc = cyc; end
    end
    chk("drain_reads", rd_cnt, 1);
    chk("drain_valid_cycles", v_cnt, 1);
    chk("drain_latency", v_cyc - rd_cyc, 2);
    @(posedge Clk); #1;

    // Mid-stream reset with a word buffered and a read in flight
    Out_Ready = 0;
    for (int i = 0; i < 3; i++) begin
      A_Req = 1; A_Data = 8'(8'h31 + i); wq.push_back(8'(8'h31 + i));
      @(posedge Clk); #1;
    end
    A_Req = 0;
    chk("mid_pre_valid", Out_Valid, 1);
    @(negedge Clk); #1; Reset = 0;
    #1; chk("mid_valid_drop", Out_Valid, 0);
    wq.delete();
    @(posedge Clk); #1; Reset = 1; Out_Ready = 1;
    v_cnt = 0;
    repeat (10) begin
      @(negedge Clk); if (Out_Valid) v_cnt++;
    end
    chk("mid_no_stale", v_cnt, 0);
    chk("wq_empty", wq.size(), 0);
    chk("oq_empty", oq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/fifo_bram_port_ctrl.md
# fifo_bram_port_ctrl

Two-producer, one-consumer controller for the BRAM-based FIFO (`FIFO_BRAM`).
- Write side: round-robin arbitration between producers A and B drives the FIFO's single write port.
- Read side: a credit-based read sequencer hides the BRAM read latency and presents the data on a valid/ready stream.
- Position: between the producer/consumer logic and the FIFO. The FIFO instance is external; the top level inverts this block's active-low reset for the FIFO's active-high `Reset`.

## Interface
- `DATA_WIDTH`, 8: word width (matches FIFO `Write_data`/`Read_data`).
- `READ_LATENCY`, 1: cycles from `FIFO_Read` high at an edge to valid `FIFO_Read_data`. Legal values: 1 or 2.
- `Clk` input 1: single clock, rising edge.
- `Reset` input 1: asynchronous, active-low reset (0 = reset).
- `A_Req` input 1: producer A has a word.
- `A_Data` input DATA_WIDTH: producer A word.
- `A_Grant` output 1: A's word is accepted at this edge.
- `B_Req`, `B_Data`, `B_Grant`: same as A, for producer B.
- `Out_Valid` output 1: `Out_Data` holds a word.
- `Out_Data` output DATA_WIDTH: head of output buffer.
- `Out_Ready` input 1: consumer takes the word at this edge when `Out_Valid` is high.
- `FIFO_Write` output 1: to FIFO `Write`.
- `FIFO_Write_data` output DATA_WIDTH: to FIFO `Write_data`.
- `FIFO_Read` output 1: to FIFO `Read`.
- `FIFO_Read_data` input DATA_WIDTH: from FIFO `Read_data`.
- `FIFO_Empty` input 1: from FIFO; registered, updated at the same edge as a read/write.
- `FIFO_Full` input 1: from FIFO; registered.

## Operation
- **Write arbiter**
  - Combinational grant: `A_Grant`/`B_Grant` = request AND `!FIFO_Full` AND arbitration win. At most one grant per cycle.
  - `FIFO_Write` = `A_Grant | B_Grant`. `FIFO_Write_data` = data of the granted producer, else `A_Data`.
  - Round-robin register `Last` (A or B) records the last producer granted.
    - Only one request: that producer wins.
    - Both request: the producer that is not `Last` wins.
    - `Last` updates only on a grant.
  - `FIFO_Full` high: no grant and no write. The producer holds `Req` and `Data` until granted.
- **Read sequencer**
  - Output buffer: BUF_DEPTH = READ_LATENCY+1 entries, circular, with pointers and a count.
  - In-flight shift register of READ_LATENCY bits tracks outstanding reads.
  - Credit = BUF_DEPTH − occupancy − in-flight reads. Occupancy is the count after this cycle's pop.
  - `FIFO_Read` (combinational) = `!FIFO_Empty` AND credit > 0. At most one read per cycle.
  - When an in-flight bit exits the shift register, capture `FIFO_Read_data` into the buffer tail.
  - Pop the buffer head on `Out_Valid & Out_Ready`. `Out_Valid` = count ≠ 0.
  - Ordering is strict FIFO; no word is dropped or duplicated.
- **States**
  - Read sequencer: EMPTY (count=0, none in flight) → FILLING (reads outstanding) → STREAMING (count>0) → back to EMPTY when drained.
  - Implement as count/in-flight flags; no separate encoded FSM is required.

## Timing
- **Reset (asynchronous, `Reset`=0):**
  - `A_Grant`, `B_Grant`, `FIFO_Write`, `FIFO_Read`, `Out_Valid` forced 0.
  - `Out_Data` = 0, `Last` = B (so A wins the first tie), buffer count = 0, in-flight = 0.
  - Release is sampled synchronously: first grant/read is possible in the first cycle with `Reset`=1.
- **Write latency:** 0 cycles. Grant and `FIFO_Write` are asserted in the same cycle as `Req`, given space.
- **Read latency, FIFO non-empty to `Out_Valid`:** READ_LATENCY+1 edges after the first `FIFO_Read` cycle.
- **Throughput:** sustained 1 word/cycle with `Out_Ready` held high and the FIFO non-empty.
- **Back-pressure:** with `Out_Ready`=0, at most BUF_DEPTH reads are issued in total, then `FIFO_Read` stays 0.
- **Reset mid-operation:** in-flight reads are discarded and the buffer is cleared. The FIFO is reset by the same net, so no state mismatch occurs.
- **Boundary conditions:**
  - Write while `FIFO_Full` with a simultaneous FIFO read: still blocked this cycle, because `Full` is registered.
  - `FIFO_Empty` with the buffer non-empty: streaming continues from the buffer.
  - Capture and pop in the same cycle: count unchanged, and both pointers advance with wrap-around.

## Test plan
- **Reset values:** hold `Reset`=0, toggle all inputs → all outputs 0. Release → with `A_Req`=`B_Req`=1, `A_Grant`=1 first.
- **Round-robin:** A and B request continuously, A_Data=0x0A, B_Data=0x0B, `Out_Ready`=1 → FIFO receives 0x0A,0x0B,0x0A,0x0B… and `Out_Data` shows the same sequence, one word/cycle after fill latency.
- **Full blocking:** force `FIFO_Full`=1 for 3 cycles with both requesting → no grants and `FIFO_Write`=0. Deassert → the granted producer is the one not served last.
- **Back-pressure:** FIFO preloaded with 0x01..0x05, `Out_Ready`=0 → exactly BUF_DEPTH `FIFO_Read` pulses (2 for READ_LATENCY=1), `Out_Data`=0x01. Raise `Out_Ready` → 0x01..0x05 delivered in order with no gaps after refill.
- **Drain to empty:** single word 0x7E → `Out_Valid` for exactly 1 cycle with `Out_Ready`=1. Afterward `FIFO_Read` stays 0 while `FIFO_Empty`=1.
- **Mid-stream reset:** pulse `Reset`=0 for half a cycle while reads are in flight → `Out_Valid` drops immediately, and no stale word appears after release.
